// File: rtl/memstream_pump_gather_if.sv
`default_nettype none
// ============================================================================
// Module      : memstream_pump_gather_if
// Description : Stream bundle for memstream_pump_gather. The narrow clk2x
//               half-word input, the slow-aligned padded output, the phase
//               flag and the FIFO level travel together.
//               slave  : the gearbox side (drives irdy/ovld/odat/level/active)
//               master : the surrounding logic (drives ivld/idat/ordy)
// Revision    : 1.0 - initial release
// ============================================================================
interface memstream_pump_gather_if #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int WIDTH_EFF = (WIDTH + 1) / 2;
    localparam int OWIDTH    = ((WIDTH + 7) / 8) * 8;
    localparam int LEVEL_W   = $clog2(FIFO_DEPTH + 1);

    logic                 active;
    logic                 irdy;
    logic                 ivld;
    logic [WIDTH_EFF-1:0] idat;
    logic                 ordy;
    logic                 ovld;
    logic [OWIDTH-1:0]    odat;
    logic [LEVEL_W-1:0]   level;

    modport slave (
        output active, irdy, ovld, odat, level,
        input  ivld, idat, ordy
    );

    modport master (
        input  active, irdy, ovld, odat, level,
        output ivld, idat, ordy
    );
endinterface
`default_nettype wire

// File: rtl/memstream_pump_gather.sv
`default_nettype none
// ============================================================================
// Module      : memstream_pump_gather
// Description : Double-pumped stream gearbox. Pairs consecutive clk2x
//               half-words into WIDTH-bit words, buffers them in a
//               FIFO_DEPTH-entry circular FIFO and presents them as a
//               byte-padded stream whose outputs only change on clk2x edges
//               that coincide with slow-clock edges.
//               Optional macro MEMSTREAM_PUMP_GATHER_STATS_EN adds the
//               stall_cnt and ovf_sticky status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module memstream_pump_gather #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic               clk2x,
    input  wire logic               rst,
`ifdef MEMSTREAM_PUMP_GATHER_STATS_EN
    output logic [31:0]             stall_cnt,
    output logic                    ovf_sticky,
`endif
    memstream_pump_gather_if.slave  s
);

    localparam int WIDTH_EFF = (WIDTH + 1) / 2;
    localparam int OWIDTH    = ((WIDTH + 7) / 8) * 8;
    localparam int c_level_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    // High half contributes only WIDTH-WIDTH_EFF bits; for odd WIDTH the
    // MSB of the second half-word is dropped.
    localparam int c_hi_w    = WIDTH - WIDTH_EFF;
    localparam logic [c_level_w-1:0] c_depth    = c_level_w'(FIFO_DEPTH);
    localparam logic [c_ptr_w-1:0]   c_last_ptr = c_ptr_w'(FIFO_DEPTH - 1);

    logic                 r_phase;
    logic                 r_h;
    logic [WIDTH_EFF-1:0] r_low;
    logic [WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic [c_level_w-1:0] r_level;
    logic                 r_ovld;
    logic [WIDTH-1:0]     r_odat;

    logic                 w_irdy;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bypass;
    logic [WIDTH-1:0]     w_word;
    logic [WIDTH-1:0]     w_head;
    logic [c_ptr_w-1:0]   w_wptr_nxt;
    logic [c_ptr_w-1:0]   w_rptr_nxt;
    logic [c_level_w-1:0] w_level_nxt;

    // Handshake decode, pointer/level next-state and post-pop head selection
    always_comb begin
        w_irdy      = (r_level < c_depth);
        w_accept    = w_irdy & s.ivld;
        w_push      = w_accept & r_h;
        // ovld only rises at an active edge and nothing pops in between, so
        // ovld=1 guarantees at least one word is held when the pop happens.
        w_pop       = r_phase & r_ovld & s.ordy;
        w_word      = {s.idat[c_hi_w-1:0], r_low};
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        if (w_push) begin
            w_wptr_nxt = (r_wptr == c_last_ptr) ? '0 : r_wptr + c_ptr_w'(1);
        end
        if (w_pop) begin
            w_rptr_nxt = (r_rptr == c_last_ptr) ? '0 : r_rptr + c_ptr_w'(1);
        end
        w_level_nxt = r_level + c_level_w'(w_push) - c_level_w'(w_pop);
        // When the FIFO is empty after the pop, the word pushed this cycle
        // becomes the head but is not in the array yet: forward it.
        w_bypass    = w_push && (r_level == c_level_w'(w_pop));
        w_head      = w_bypass ? w_word : r_mem[w_rptr_nxt];
    end

    // Fast/slow phase tracker; high in the cycle that ends on a slow edge
    always_ff @(posedge clk2x) begin
        if (rst) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    // Half-word pairing: hold the low half until its partner arrives
    always_ff @(posedge clk2x) begin
        if (rst) begin
            r_h   <= 1'b0;
            r_low <= '0;
        end else if (w_accept) begin
            if (!r_h) begin
                r_low <= s.idat;
                r_h   <= 1'b1;
            end else begin
                r_h   <= 1'b0;
            end
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk2x) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk2x) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
        end
    end

    // Output register: refreshed only on edges that coincide with slow edges
    always_ff @(posedge clk2x) begin
        if (rst) begin
            r_ovld <= 1'b0;
            r_odat <= '0;
        end else if (r_phase) begin
            r_ovld <= (w_level_nxt != '0);
            if (w_level_nxt != '0) begin
                r_odat <= w_head;
            end
        end
    end

    assign s.active = r_phase;
    assign s.irdy   = w_irdy;
    assign s.ovld   = r_ovld;
    assign s.odat   = OWIDTH'(r_odat);
    assign s.level  = r_level;

`ifdef MEMSTREAM_PUMP_GATHER_STATS_EN
    logic [31:0] r_stall_cnt;
    logic        r_ovf_sticky;

    // Count slow cycles where a word is offered but the consumer stalls
    always_ff @(posedge clk2x) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_phase && r_ovld && !s.ordy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    // Remember any attempt to push a half-word while not ready
    always_ff @(posedge clk2x) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (s.ivld && !w_irdy) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign ovf_sticky = r_ovf_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memstream_pump_gather.sv
`default_nettype none
// ============================================================================
// Module      : tb_memstream_pump_gather
// Description : Scoreboard bench for memstream_pump_gather. Stimulus pushes
//               the expected full words into queues; monitors pop and compare
//               each word transferred on a slow edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memstream_pump_gather;

    logic clk2x = 1'b0;
    logic rst   = 1'b1;

    always #5 clk2x = ~clk2x;

    memstream_pump_gather_if #(.WIDTH(32), .FIFO_DEPTH(3)) bus  ();
    memstream_pump_gather_if #(.WIDTH(7),  .FIFO_DEPTH(2)) bus7 ();

`ifdef MEMSTREAM_PUMP_GATHER_STATS_EN
    logic [31:0] stall_cnt;
    logic        ovf_sticky;
    logic [31:0] stall_cnt7;
    logic        ovf_sticky7;
`endif

    memstream_pump_gather #(.WIDTH(32), .FIFO_DEPTH(3)) dut (
        .clk2x      (clk2x),
        .rst        (rst),
`ifdef MEMSTREAM_PUMP_GATHER_STATS_EN
        .stall_cnt  (stall_cnt),
        .ovf_sticky (ovf_sticky),
`endif
        .s          (bus)
    );

    memstream_pump_gather #(.WIDTH(7), .FIFO_DEPTH(2)) dut7 (
        .clk2x      (clk2x),
        .rst        (rst),
`ifdef MEMSTREAM_PUMP_GATHER_STATS_EN
        .stall_cnt  (stall_cnt7),
        .ovf_sticky (ovf_sticky7),
`endif
        .s          (bus7)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q  [$];
    logic [7:0]  q7 [$];
    logic        m_h;
    logic [15:0] m_low;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk2x);
        #1;
    endtask

    // Offer one half-word; waits (bounded) for irdy and updates the pairing model
    task automatic send(input logic [15:0] d, output int waited);
        waited   = 0;
        bus.ivld = 1'b1;
        bus.idat = d;
        while (!bus.irdy && waited < 200) begin
            tick();
            waited++;
        end
        chk("send_irdy", bus.irdy, 1);
        if (bus.irdy) begin
            if (!m_h) begin
                m_low = d;
                m_h   = 1'b1;
            end else begin
                q.push_back({d, m_low});
                m_h = 1'b0;
            end
            tick();
        end
        bus.ivld = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        bus.ordy = 1'b1;
        while ((q.size() != 0 || bus.ovld) && k < 200) begin
            tick();
            k++;
        end
        chk({nm, "_drained"}, 64'(q.size()), 0);
        chk({nm, "_level0"}, bus.level, 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        m_h = 1'b0;
    endtask

    // Monitor for the 32-bit instance: compare each word taken on a slow edge
    always @(negedge clk2x) begin
        if (!rst && bus.active && bus.ovld && bus.ordy) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL word32: got unexpected 0x%0h, required no transfer @%0t", bus.odat, $time);
            end else begin
                chk("word32", bus.odat, q.pop_front());
            end
        end
    end

    // Monitor for the 7-bit instance
    always @(negedge clk2x) begin
        if (!rst && bus7.active && bus7.ovld && bus7.ordy) begin
            if (q7.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL word7: got unexpected 0x%0h, required no transfer @%0t", bus7.odat, $time);
            end else begin
                chk("word7", bus7.odat, q7.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int k;
        logic [31:0] s0;
        bus.ivld  = 1'b0;
        bus.idat  = '0;
        bus.ordy  = 1'b0;
        bus7.ivld = 1'b0;
        bus7.idat = '0;
        bus7.ordy = 1'b0;
        m_h       = 1'b0;
        m_low     = '0;

        repeat (4) tick();
        rst = 1'b0;
        chk("rst_active", bus.active, 0);
        chk("rst_ovld",   bus.ovld,   0);
        chk("rst_odat",   bus.odat,   0);
        chk("rst_level",  bus.level,  0);
        chk("rst_irdy",   bus.irdy,   1);

        // Streaming at full rate: one word per slow cycle, no backpressure
        bus.ordy = 1'b1;
        send(16'h1111, w); chk("t1_wait", w, 0); chk("t1_lvl", bus.level <= 1, 1);
        send(16'h2222, w); chk("t1_wait", w, 0); chk("t1_lvl", bus.level <= 1, 1);
        send(16'h3333, w); chk("t1_wait", w, 0); chk("t1_lvl", bus.level <= 1, 1);
        send(16'h4444, w); chk("t1_wait", w, 0); chk("t1_lvl", bus.level <= 1, 1);
        drain("t1");

        // Odd width: high half MSB dropped, pad bit zero
        bus7.ordy = 1'b1;
        bus7.ivld = 1'b1;
        bus7.idat = 4'h5;
        chk("t2_irdy", bus7.irdy, 1);
        tick();
        bus7.idat = 4'hF;
        q7.push_back(8'h75);
        tick();
        bus7.ivld = 1'b0;
        k = 0;
        while (q7.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        chk("t2_drained", 64'(q7.size()), 0);

        // Backpressure fills the FIFO; held half-word waits for space
        bus.ordy = 1'b0;
        for (int i = 1; i <= 6; i++) send(16'(i) * 16'h1111, w);
        chk("t3_irdy_full", bus.irdy, 0);
        chk("t3_level_full", bus.level, 3);
        bus.ivld = 1'b1;
        bus.idat = 16'h7777;
        repeat (4) begin
            tick();
            chk("t3_hold_irdy", bus.irdy, 0);
        end
        bus.ordy = 1'b1;
        for (int i = 7; i <= 10; i++) send(16'(i) * 16'h1111, w);
        drain("t3");

        // ordy high only in inactive cycles must not pop
        bus.ordy = 1'b0;
        send(16'hAAAA, w);
        send(16'hBBBB, w);
        repeat (3) tick();
        chk("t4_ovld", bus.ovld, 1);
        repeat (8) begin
            bus.ordy = (bus.active == 1'b0);
            tick();
        end
        bus.ordy = 1'b0;
        chk("t4_odat",  bus.odat,  32'hBBBB_AAAA);
        chk("t4_level", bus.level, 1);
        chk("t4_ovld2", bus.ovld,  1);
        drain("t4");

        // Reset with two words and a pending low half
        bus.ordy = 1'b0;
        for (int i = 1; i <= 5; i++) send(16'(i) * 16'h0101, w);
        chk("t5_level_pre", bus.level, 2);
        pulse_rst();
        chk("t5_level",  bus.level,  0);
        chk("t5_ovld",   bus.ovld,   0);
        chk("t5_odat",   bus.odat,   0);
        chk("t5_active", bus.active, 0);
        chk("t5_irdy",   bus.irdy,   1);
        send(16'h0606, w);
        send(16'h0707, w);
        drain("t5");

`ifdef MEMSTREAM_PUMP_GATHER_STATS_EN
        pulse_rst();
        chk("t6_stall0", stall_cnt, 0);
        chk("t6_ovf0", ovf_sticky, 0);
        bus.ordy = 1'b0;
        send(16'h1234, w);
        send(16'h5678, w);
        k = 0;
        while (!bus.ovld && k < 10) begin
            tick();
            k++;
        end
        if (bus.active) tick();
        s0 = stall_cnt;
        repeat (10) tick();
        chk("t6_stall_delta", stall_cnt - s0, 5);
        for (int i = 1; i <= 4; i++) send(16'(i) * 16'h0011, w);
        chk("t6_full", bus.irdy, 0);
        chk("t6_ovf_pre", ovf_sticky, 0);
        bus.ivld = 1'b1;
        tick();
        bus.ivld = 1'b0;
        chk("t6_ovf_set", ovf_sticky, 1);
        repeat (3) tick();
        chk("t6_ovf_hold", ovf_sticky, 1);
        pulse_rst();
        chk("t6_ovf_clr", ovf_sticky, 0);
`endif

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
